// File: rtl/adder_16bit_multiword_seq.sv
// Wide adder sequencer: walks one 16-bit slice per cycle through an external
// combinational adder_16bit, chaining the carry, and returns the assembled sum.
module adder_16bit_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  input  logic                  op_cin,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout,
  input  logic                  add_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  overflow
);

  localparam int DATA_W = 16 * WORDS;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              carry_reg;
  logic [15:0]       a_w   [WORDS];
  logic [15:0]       b_w   [WORDS];
  logic [15:0]       res_w [WORDS];

  // Word views of the operand/result registers so slice selection is a plain array index.
  for (genvar g = 0; g < WORDS; g++) begin : g_slice
    assign a_w[g]              = a_reg[16*g +: 16];
    assign b_w[g]              = b_reg[16*g +: 16];
    assign result[16*g +: 16]  = res_w[g];
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_w[idx];
      add_b   = b_w[idx];
      add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < WORDS; i++) res_w[i] <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_w[idx] <= add_sum;
          carry_reg  <= add_cout;
          // Only the top slice's flags describe the full-width add.
          if (idx == LAST_IDX) begin
            cout     <= add_cout;
            overflow <= add_overflow;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_16bit_multiword_seq.sv
// Bench for the wide adder sequencer with a behavioural 16-bit adder attached.
module tb_adder_16bit_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout, add_overflow;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         cout, overflow;

  always #5 clk = ~clk;

  // 16-bit adder slice
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};
  assign add_overflow = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

  adder_16bit_multiword_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    vec_t v;
    logic [W:0] s;
    s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    v.a   = a;
    v.b   = b;
    v.cin = cin;
    v.res = s[W-1:0];
    v.co  = s[W];
    v.ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return v;
  endfunction

  // Drives one operation, checks the per-slice adder drive and latency, then
  // compares the result against the scoreboard head. bp holds out_ready low.
  task automatic run_op(input vec_t v, input bit bp);
    int   t;
    logic c;
    logic [16:0] s;
    vec_t e;
    logic [W-1:0] held_res;
    logic held_co, held_ov;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("in_ready_before_accept", W'(in_ready), W'(1));
    out_ready = !bp;
    op_a = v.a; op_b = v.b; op_cin = v.cin; in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    c = v.cin;
    for (int k = 0; k < WORDS; k++) begin
      chk($sformatf("slice%0d_add_a", k), W'(add_a), W'(v.a[16*k +: 16]));
      chk($sformatf("slice%0d_add_cin", k), W'(add_cin), W'(c));
      chk($sformatf("slice%0d_busy", k), W'({in_ready, out_valid}), W'(0));
      s = {1'b0, v.a[16*k +: 16]} + {1'b0, v.b[16*k +: 16]} + {16'h0, c};
      c = s[16];
      @(posedge clk); #1;
    end
    chk("latency_out_valid", W'(out_valid), W'(1));
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!out_valid || sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: out_valid=%0b queued=%0d", out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    chk("result", result, e.res);
    chk("cout", W'(cout), W'(e.co));
    chk("overflow", W'(overflow), W'(e.ov));
    chk("idle_adder_drive", W'({add_a, add_b, add_cin}), W'(0));
    if (bp) begin
      held_res = result; held_co = cout; held_ov = overflow;
      for (int k = 0; k < 5; k++) begin
        if (k == 2) begin
          in_valid = 1'b1; op_a = {W{1'b1}}; op_b = {W{1'b1}}; op_cin = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_out_valid", W'(out_valid), W'(1));
        chk("bp_in_ready", W'(in_ready), W'(0));
        chk("bp_result_stable", result, held_res);
        chk("bp_flags_stable", W'({cout, overflow}), W'({held_co, held_ov}));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_out_valid", W'(out_valid), W'(0));
    chk("release_in_ready", W'(in_ready), W'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_cin = 1'b0;

    tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h2222_2222_2222_2212, 1'b0, 1'b0};
    for (int i = 6; i < 10; i++)
      tbl[i] = mk({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready_low", W'(in_ready), W'(0));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_result", result, '0);
    chk("reset_flags", W'({cout, overflow}), W'(0));
    chk("reset_adder_drive", W'({add_a, add_b, add_cin}), W'(0));
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 10; i++) run_op(tbl[i], 1'b0);

    // Backpressure with an ignored input pulse, then a fresh op after it.
    run_op(tbl[2], 1'b1);
    run_op(tbl[5], 1'b0);

    // Reset while the third slice is in flight.
    op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1111_2222_3333_4444; op_cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_run_slice2_add_a", W'(add_a), W'(16'hBBBB));
    rst_n = 1'b0;
    #1;
    chk("reset_forces_in_ready_low", W'(in_ready), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_adder_drive", W'({add_a, add_b, add_cin}), W'(0));
    chk("abort_result", result, '0);
    chk("abort_flags", W'({cout, overflow}), W'(0));
    chk("abort_in_ready", W'(in_ready), W'(1));
    run_op('{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0}, 1'b0);

    chk("scoreboard_drained", W'(sb.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_16bit_multiword_seq.md
Name: adder_16bit_multiword_seq

Overview:
- Sequencer that performs wide (WORDS×16-bit) additions by time-multiplexing one adder_16bit instance.
- Upstream: accepts wide operands on a valid/ready handshake.
- Per cycle: drives one 16-bit slice, plus the chained carry, into adder_16bit, and consumes its sum/cout/overflow.
- Downstream: returns the assembled wide result, final carry and signed overflow on a valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit slices per operation (minimum 1); operand width W = 16×WORDS.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  in  1  wide operands valid
- in_ready  out  1  sequencer can accept operands
- op_a  in  W  operand A
- op_b  in  W  operand B
- op_cin  in  1  carry-in to least-significant slice
- add_a  out  16  slice of A driven to adder_16bit.a
- add_b  out  16  slice of B driven to adder_16bit.b
- add_cin  out  1  chained carry driven to adder_16bit.cin
- add_sum  in  16  adder_16bit.sum
- add_cout  in  1  adder_16bit.cout
- add_overflow  in  1  adder_16bit.overflow
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  wide sum
- cout  out  1  carry out of most-significant slice
- overflow  out  1  signed (two's-complement) overflow of the full W-bit add

Behaviour:
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op_a, op_b into registers, set carry_reg=op_cin, idx=0, go to RUN.
  - RUN: in_ready=0; add_a=a_reg[16*idx+:16], add_b=b_reg[16*idx+:16], add_cin=carry_reg, all decoded from registers only. Each edge: result[16*idx+:16]<=add_sum, carry_reg<=add_cout.
    - idx<WORDS-1: idx<=idx+1.
    - idx==WORDS-1: cout<=add_cout, overflow<=add_overflow, go to DONE.
  - DONE: out_valid=1; result, cout and overflow held stable. On out_ready, go to IDLE (out_valid=0 next cycle).
- Adder-facing outputs: add_a, add_b, add_cin are 0 in IDLE and DONE.
- Adder is combinational; its response to slice idx is sampled on the same edge that advances idx.
- Latency: accept at edge 0 → slices captured at edges 1..WORDS → out_valid high after edge WORDS.
- Throughput: one operation per WORDS+2 cycles with out_ready held high (one IDLE cycle between operations; no accept while in DONE).
- Overflow and carry rules:
  - overflow is taken from the top slice only; intermediate slice overflow flags are ignored.
  - cout is the top-slice carry. Both are fully determined by W-bit arithmetic: {cout,result} = op_a + op_b + op_cin.
- WORDS=1: single RUN cycle, out_valid after edge 1.
- Input stability: in_valid while not in IDLE is ignored (in_ready=0); op_* only need to be stable at the accept edge.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable.
- Reset (rst_n low at any edge, including mid-RUN or mid-DONE): state=IDLE, idx=0, carry_reg=0, result=0, cout=0, overflow=0, out_valid=0, add_*=0. In-flight operation is discarded.
- in_ready is forced 0 while rst_n is low and is 1 from the first cycle after reset is released.

Test Plan (WORDS=4, real adder_16bit connected):
- A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → result 0x0000_0000_0001_0000, cout=0, overflow=0; out_valid rises exactly 4 edges after accept.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → result 0, cout=1, overflow=0; add_cin=1 observed on all four slices.
- A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → result 0x8000_0000_0000_0000, cout=0, overflow=1.
- A=B=0x8000_0000_0000_0000, cin=0 → result 0, cout=1, overflow=1; then A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → result 0, cout=1, overflow=0.
- Backpressure: out_ready low for 5 cycles after out_valid, in_valid pulsed meanwhile → result/flags stable, in_ready=0, pulse ignored; out_ready high → out_valid low next cycle, in_ready high.
- rst_n low for one edge while idx=2 → next cycle IDLE, out_valid=0, add_*=0, result=0; a following op 0x1+0x2 completes with result 0x3, cout=0, overflow=0.
